// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the register-file write-port controller
package ibex_pkg;
  typedef enum logic {RF_WCTRL_CLEAR, RF_WCTRL_RUN} rf_wctrl_state_e;
endpackage

// File: rtl/ibex_rf_wport_ctrl.sv
// ibex_rf_wport_ctrl: arbitrates primary writeback, a buffered secondary writer and a clear sweep onto one RF write port
module ibex_rf_wport_ctrl
  import ibex_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumRegs = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit ClearOnReset = 1'b1,
  parameter int SecMaxWait = 4,
  localparam int AddrWidth = $clog2(NumRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_valid_i,
  input  logic [AddrWidth-1:0] wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic                 sec_valid_i,
  input  logic [AddrWidth-1:0] sec_addr_i,
  input  logic [DataWidth-1:0] sec_data_i,
  output logic                 sec_ready_o,
  output logic                 wb_stall_o,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 rf_we_o,
  output logic [AddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 pend_valid_o,
  output logic [AddrWidth-1:0] pend_addr_o,
  output logic [DataWidth-1:0] pend_data_o,
  output logic                 err_o
);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumRegs - 1);
  localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);
  localparam rf_wctrl_state_e ResetState = ClearOnReset ? RF_WCTRL_CLEAR : RF_WCTRL_RUN;
  rf_wctrl_state_e state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d, pend_addr_q, pend_addr_d;
  logic [DataWidth-1:0] pend_data_q, pend_data_d;
  logic pend_valid_q, pend_valid_d, stall_q, stall_d, err_q, err_d;
  logic [3:0] wait_q, wait_d;
  logic run, wb_act, squash, drain, blocked, load;
  assign run     = state_q == RF_WCTRL_RUN;
  assign wb_act  = wb_valid_i && |wb_addr_i;
  assign squash  = run && pend_valid_q && wb_act && wb_addr_i == pend_addr_q;
  assign drain   = run && pend_valid_q && !wb_act && !clear_req_i;
  assign blocked = run && pend_valid_q && wb_act && !squash && !clear_req_i && !stall_q;
  assign load    = sec_valid_i && sec_ready_o && |sec_addr_i && !clear_req_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ResetState;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = run ? (clear_req_i ? RF_WCTRL_CLEAR : RF_WCTRL_RUN)
                  : (cnt_q == LastAddr ? RF_WCTRL_RUN : RF_WCTRL_CLEAR);
  end
  // Primary has priority in RUN; the buffer only gets the port on idle primary cycles.
  always_comb begin
    sec_ready_o  = run && !pend_valid_q;
    clear_busy_o = !run;
    rf_we_o      = run ? (wb_act || drain) : 1'b1;
    rf_waddr_o   = !run ? cnt_q : wb_act ? wb_addr_i : pend_addr_q;
    rf_wdata_o   = !run ? WordZeroVal : wb_act ? wb_data_i : pend_data_q;
  end
  always_comb begin
    cnt_d        = (run || cnt_q == LastAddr) ? FirstAddr : cnt_q + FirstAddr;
    pend_valid_d = load ? 1'b1 : (clear_req_i || drain || squash) ? 1'b0 : pend_valid_q;
    pend_addr_d  = load ? sec_addr_i : pend_addr_q;
    pend_data_d  = load ? sec_data_i : pend_data_q;
    wait_d       = blocked ? wait_q + 4'd1 : 4'd0;
    stall_d      = blocked && (wait_q + 4'd1 == 4'(SecMaxWait));
    err_d        = wb_act && (!run || stall_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= FirstAddr;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      wait_q       <= '0;
      stall_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      wait_q       <= wait_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
    end
  end
  assign wb_stall_o   = stall_q;
  assign err_o        = err_q;
  assign pend_valid_o = pend_valid_q;
  assign pend_addr_o  = pend_addr_q;
  assign pend_data_o  = pend_data_q;
endmodule

// File: tb/tb_ibex_rf_wport_ctrl.sv
// tb_ibex_rf_wport_ctrl: directed scenarios for the RF write-port controller
module tb_ibex_rf_wport_ctrl;
  logic clk = 1'b0, rst;
  logic wb_valid, sec_valid, clear_req;
  logic [4:0] wb_addr, sec_addr;
  logic [31:0] wb_data, sec_data;
  logic sec_ready, wb_stall, clear_busy, rf_we, pend_valid, err;
  logic [4:0] rf_waddr, pend_addr;
  logic [31:0] rf_wdata, pend_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ibex_rf_wport_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .sec_valid_i(sec_valid), .sec_addr_i(sec_addr), .sec_data_i(sec_data),
    .sec_ready_o(sec_ready), .wb_stall_o(wb_stall),
    .clear_req_i(clear_req), .clear_busy_o(clear_busy),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pend_valid_o(pend_valid), .pend_addr_o(pend_addr), .pend_data_o(pend_data),
    .err_o(err)
  );
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    sec_valid = 0; sec_addr = 0; sec_data = 0; clear_req = 0;
  endtask
  task automatic sweep(input string name, input int ignore_at);
    for (int i = 1; i < 32; i++) begin
      clear_req = (i == ignore_at);
      #1;
      checks++;
      if ({clear_busy, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'(i), 32'h0}) begin
        errors++;
        $display("FAIL %s step %0d got busy=%b we=%b a=%0d d=%h", name, i, clear_busy, rf_we, rf_waddr, rf_wdata);
      end
      cyc();
    end
    clear_req = 0;
    #1;
    checks++;
    if ({clear_busy, rf_we} !== 2'b00) begin
      errors++;
      $display("FAIL %s_end got busy=%b we=%b exp 0 0", name, clear_busy, rf_we);
    end
  endtask
  task automatic load_buf(input logic [4:0] a, input logic [31:0] d);
    sec_valid = 1; sec_addr = a; sec_data = d;
    cyc();
    sec_valid = 0;
    #1;
  endtask
  task automatic test_reset();
    idle();
    rst = 1;
    #12;
    checks++;
    if ({clear_busy, pend_valid, pend_addr, pend_data, wb_stall, err, sec_ready} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got busy=%b pv=%b pa=%0d pd=%h st=%b err=%b rdy=%b", clear_busy, pend_valid, pend_addr, pend_data, wb_stall, err, sec_ready);
    end
    @(negedge clk);
    rst = 0;
    #1;
  endtask
  task automatic test_clear_sweep();
    for (int i = 1; i < 32; i++) begin
      wb_valid = (i == 10); wb_addr = 5'd4; wb_data = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(i), 32'h0}) begin
        errors++;
        $display("FAIL sweep step %0d got we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata);
      end
      if (i == 11 || i == 12) begin
        checks++;
        if (err !== (i == 11)) begin
          errors++;
          $display("FAIL sweep_err step %0d got %b exp %b", i, err, i == 11);
        end
      end
      cyc();
    end
    idle();
    #1;
    checks++;
    if ({clear_busy, rf_we, sec_ready} !== 3'b001) begin
      errors++;
      $display("FAIL sweep_end got busy=%b we=%b rdy=%b exp 0 0 1", clear_busy, rf_we, sec_ready);
    end
  endtask
  task automatic test_sec_write();
    sec_valid = 1; sec_addr = 5'd5; sec_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({sec_ready, rf_we} !== 2'b10) begin
      errors++;
      $display("FAIL sec_accept got rdy=%b we=%b exp 1 0", sec_ready, rf_we);
    end
    cyc();
    sec_valid = 0;
    #1;
    checks++;
    if ({pend_valid, pend_addr, pend_data, sec_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sec_drain got pv=%b rdy=%b we=%b a=%0d d=%h", pend_valid, sec_ready, rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    checks++;
    if ({pend_valid, sec_ready, rf_we} !== 3'b010) begin
      errors++;
      $display("FAIL sec_done got pv=%b rdy=%b we=%b exp 0 1 0", pend_valid, sec_ready, rf_we);
    end
  endtask
  task automatic test_squash();
    load_buf(5'd7, 32'h1111);
    wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h2222;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h2222}) begin
      errors++;
      $display("FAIL squash_write got we=%b a=%0d d=%h exp 1 7 2222", rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    idle();
    #1;
    checks++;
    if ({pend_valid, rf_we, sec_ready} !== 3'b001) begin
      errors++;
      $display("FAIL squash_after got pv=%b we=%b rdy=%b exp 0 0 1", pend_valid, rf_we, sec_ready);
    end
  endtask
  task automatic block4();
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1; wb_addr = 5'd9; wb_data = 32'(i);
      #1;
      checks++;
      if ({wb_stall, pend_valid, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd9, 32'(i)}) begin
        errors++;
        $display("FAIL blocked %0d got st=%b pv=%b a=%0d d=%h", i, wb_stall, pend_valid, rf_waddr, rf_wdata);
      end
      cyc();
    end
  endtask
  task automatic test_starve();
    load_buf(5'd3, 32'h3333);
    block4();
    idle();
    #1;
    checks++;
    if ({wb_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd3, 32'h3333}) begin
      errors++;
      $display("FAIL stall_drain got st=%b we=%b a=%0d d=%h", wb_stall, rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    checks++;
    if ({wb_stall, pend_valid, err} !== 3'b000) begin
      errors++;
      $display("FAIL stall_end got st=%b pv=%b err=%b exp 0 0 0", wb_stall, pend_valid, err);
    end
  endtask
  task automatic test_stall_violation();
    load_buf(5'd3, 32'h4444);
    block4();
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h9999;
    #1;
    checks++;
    if ({wb_stall, rf_we, rf_waddr, rf_wdata, err} !== {1'b1, 1'b1, 5'd9, 32'h9999, 1'b0}) begin
      errors++;
      $display("FAIL viol_wins got st=%b we=%b a=%0d d=%h err=%b", wb_stall, rf_we, rf_waddr, rf_wdata, err);
    end
    cyc();
    idle();
    #1;
    checks++;
    if ({err, wb_stall, pend_valid, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h4444}) begin
      errors++;
      $display("FAIL viol_err got err=%b st=%b pv=%b we=%b a=%0d d=%h", err, wb_stall, pend_valid, rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    checks++;
    if ({err, pend_valid} !== 2'b00) begin
      errors++;
      $display("FAIL viol_done got err=%b pv=%b exp 0 0", err, pend_valid);
    end
  endtask
  task automatic test_clear_req();
    load_buf(5'd6, 32'h6666);
    clear_req = 1;
    #1;
    checks++;
    if ({pend_valid, rf_we} !== 2'b10) begin
      errors++;
      $display("FAIL clr_req got pv=%b we=%b exp 1 0", pend_valid, rf_we);
    end
    cyc();
    clear_req = 0;
    #1;
    checks++;
    if ({clear_busy, pend_valid, sec_ready} !== 3'b100) begin
      errors++;
      $display("FAIL clr_enter got busy=%b pv=%b rdy=%b exp 1 0 0", clear_busy, pend_valid, sec_ready);
    end
    sweep("resweep", 3);
  endtask
  task automatic test_sec_zero();
    sec_valid = 1; sec_addr = 5'd0; sec_data = 32'hABCD;
    #1;
    checks++;
    if (sec_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %b exp 1", sec_ready);
    end
    cyc();
    sec_valid = 0;
    #1;
    checks++;
    if ({pend_valid, rf_we, sec_ready} !== 3'b001) begin
      errors++;
      $display("FAIL x0_drop got pv=%b we=%b rdy=%b exp 0 0 1", pend_valid, rf_we, sec_ready);
    end
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL wb_x0 got we=%b exp 0", rf_we);
    end
    idle();
  endtask
  task automatic test_reset_mid();
    load_buf(5'd8, 32'h8888);
    #2 rst = 1;
    #1;
    checks++;
    if ({pend_valid, clear_busy, wb_stall, err} !== 4'b0100) begin
      errors++;
      $display("FAIL async_rst got pv=%b busy=%b st=%b err=%b", pend_valid, clear_busy, wb_stall, err);
    end
    @(negedge clk);
    rst = 0;
    #1;
    sweep("post_rst", 0);
  endtask
  initial begin
    test_reset();
    test_clear_sweep();
    test_sec_write();
    test_squash();
    test_starve();
    test_stall_violation();
    test_clear_req();
    test_sec_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_rf_wport_ctrl.md
IBEX_RF_WPORT_CTRL -- requirements
Module: ibex_rf_wport_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register word width.
REQ-002 SHALL have parameter NumRegs, default 32, register count; AddrWidth = $clog2(NumRegs).
REQ-003 SHALL have parameter WordZeroVal, default '0, value written by clear sweep.
REQ-004 SHALL have parameter ClearOnReset, default 1, start clear sweep on reset exit.
REQ-005 SHALL have parameter SecMaxWait, default 4, range 1..15, secondary starvation limit in cycles.
REQ-006 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports wb_valid_i/wb_addr_i/wb_data_i  input  1/AddrWidth/DataWidth  primary writeback, no backpressure.
REQ-009 SHALL have ports sec_valid_i/sec_addr_i/sec_data_i  input  1/AddrWidth/DataWidth  secondary write request.
REQ-010 SHALL have port sec_ready_o  output  1  secondary accept.
REQ-011 SHALL have port wb_stall_o  output  1  primary must not write this cycle.
REQ-012 SHALL have port clear_req_i  input  1  request clear sweep.
REQ-013 SHALL have port clear_busy_o  output  1  sweep in progress.
REQ-014 SHALL have ports rf_we_o/rf_waddr_o/rf_wdata_o  output  1/AddrWidth/DataWidth  register file write port.
REQ-015 SHALL have ports pend_valid_o/pend_addr_o/pend_data_o  output  1/AddrWidth/DataWidth  buffered secondary write, for read forwarding.
REQ-016 SHALL have port err_o  output  1  one-cycle protocol-violation pulse.

Function
REQ-017 SHALL implement FSM states CLEAR and RUN.
REQ-018 In CLEAR, SHALL drive rf_we_o=1, rf_wdata_o=WordZeroVal, rf_waddr_o=sweep counter, counter stepping 1..NumRegs-1 one per cycle, then enter RUN; sweep takes exactly NumRegs-1 cycles.
REQ-019 clear_busy_o SHALL equal (state==CLEAR).
REQ-020 In RUN, clear_req_i=1 SHALL enter CLEAR next cycle, restart counter at 1, and discard any buffered secondary entry; clear_req_i in CLEAR SHALL be ignored.
REQ-021 In RUN, wb_valid_i=1 with wb_addr_i!=0 SHALL drive rf_we_o/rf_waddr_o/rf_wdata_o combinationally from wb inputs, zero latency.
REQ-022 sec_ready_o SHALL equal (state==RUN && !pend_valid_o); handshake sec_valid_i&&sec_ready_o loads the one-entry buffer at the clock edge.
REQ-023 Accepted secondary writes to address 0 SHALL be dropped without loading the buffer.
REQ-024 Buffer SHALL drain to the write port in any RUN cycle with wb_valid_i=0 (or wb_addr_i=0), clearing pend_valid_o next cycle; minimum secondary latency 1 cycle.
REQ-025 If wb writes pend_addr_o while buffer valid, buffer SHALL be squashed (primary newer), with no secondary write issued.
REQ-026 Wait counter SHALL increment each cycle buffer valid and blocked by wb, reset on drain/squash/clear; at SecMaxWait, wb_stall_o SHALL assert (registered) for exactly one cycle, during which buffer drains.
REQ-027 wb_valid_i=1 with wb_addr_i!=0 while wb_stall_o=1 or in CLEAR SHALL pulse err_o; primary write still wins in RUN, is discarded in CLEAR.
REQ-028 rf_we_o SHALL never assert with rf_waddr_o=0.

Reset
REQ-029 During/after reset: state=CLEAR if ClearOnReset else RUN, counter=1, pend_valid_o=0, pend_addr_o=0, pend_data_o=0, wb_stall_o=0, err_o=0, wait counter=0.
REQ-030 Reset assertion mid-sweep or with buffer valid SHALL abandon all activity immediately.

Structure
REQ-031 State enum rf_wctrl_state_e SHALL live in ibex_pkg; all else local.
REQ-032 No sub-module; FSM, buffer and counters SHALL be inline.

Verification
REQ-033 Reset release, ClearOnReset=1, NumRegs=32 -> 31 writes of WordZeroVal to x1..x31, clear_busy_o low on cycle 32.
REQ-034 RUN, sec write x5=0xDEAD_BEEF, no wb -> sec_ready_o drops, rf write x5 next cycle, sec_ready_o back.
REQ-035 Buffer x7=0x1111, wb writes x7=0x2222 same cycle -> only 0x2222 written, pend_valid_o clears.
REQ-036 Buffer x3, wb writes x9 continuously -> wb_stall_o high on 5th blocked cycle (SecMaxWait=4), x3 written then; wb during stall -> err_o pulse.
REQ-037 clear_req_i with buffer valid -> buffer discarded, sweep restarts at x1; sec write to x0 -> accepted, no rf_we_o.
